lsu_ctrl: RTL and testbench

// Load/store sequencer between the core's memory stage and main_mem's data port.

---
 rtl/lsu_ctrl_pkg.sv | 50 +++++
 rtl/lsu_ctrl_align.sv | 68 ++++++
 rtl/lsu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer.
//   lsu_op_e      request opcode (load / store / fence.i / illegal)
//   LS_*          RV32 funct3 width/sign encodings for loads and stores
//   lsu_state_e   sequencer FSM states
//   lsu_fault()   request legality / alignment check done at accept time
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_STORE   = 2'b01,
    OP_FENCE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } lsu_op_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDATA,
    S_FENCE,
    S_FSETTLE,
    S_RESP
  } lsu_state_e;

  // Returns 1 when the request must complete as a fault without touching memory.
  function automatic logic lsu_fault(input logic [1:0] op,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LOAD:  bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_STORE: bad = (funct3 >= 3'b011);
      OP_FENCE: bad = 1'b0;
      default:  bad = 1'b1;
    endcase
    if ((op == OP_LOAD) || (op == OP_STORE)) begin
      // Halfword (H/HU) must be 2-byte aligned, word must be 4-byte aligned.
      if ((funct3[1:0] == 2'b01) && addr_lo[0]) bad = 1'b1;
      if ((funct3 == LS_W) && (addr_lo != 2'b00)) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Combinational lane logic for the load/store sequencer.
//   funct3    in   3   access width/sign
//   addr_lo   in   2   byte offset within the word
//   st_data   in   32  store source data (rs2)
//   ld_word   in   32  raw word read from memory
//   st_ben    out  4   store byte enables
//   st_wdata  out  32  store data replicated across lanes
//   ld_data   out  32  selected, sign/zero-extended load result
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_ben,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_ben   = 4'b1111;
    st_wdata = st_data;
    case (funct3)
      LS_B, LS_BU: begin
        case (addr_lo)
          2'd0:    st_ben = 4'b0001;
          2'd1:    st_ben = 4'b0010;
          2'd2:    st_ben = 4'b0100;
          default: st_ben = 4'b1000;
        endcase
        st_wdata = {4{st_data[7:0]}};
      end
      LS_H, LS_HU: begin
        st_ben   = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_ben   = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
  end

  always_comb begin
    case (funct3)
      LS_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LS_BU:   ld_data = {24'h0, ld_byte};
      LS_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LS_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the core memory stage and main_mem's data port.
// One request in flight; handles load, store, fence.i and faulting requests.
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_valid/o_ready                  request handshake (o_ready = idle)
//   i_op, i_funct3, i_addr, i_wdata  request fields
//   o_done, o_fault, o_rdata         completion pulse, fault flag, extended load data
//   o_dm_*/i_dm_rdata                main_mem data port
//   o_fence_i, i_mem_ready           fence.i pulse and main_mem ready
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned FENCE_SETTLE = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_op,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_done,
  output logic              o_fault,
  output logic [31:0]       o_rdata,
  output logic              o_dm_ren,
  output logic              o_dm_wen,
  output logic [3:0]        o_dm_ben,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [31:0]       o_dm_wdata,
  input  logic [31:0]       i_dm_rdata,
  output logic              o_fence_i,
  input  logic              i_mem_ready
);

  localparam int unsigned CNT_W = (FENCE_SETTLE < 1) ? 1 : $clog2(FENCE_SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(FENCE_SETTLE);

  lsu_state_e        state, state_nxt;
  lsu_op_e           op_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              fault_q;
  logic [CNT_W-1:0]  settle_cnt;
  logic [31:0]       rdata_q;
  logic              accept;
  logic              req_fault;

  logic [3:0]        st_ben;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;

  // Address bits above the main_mem window are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:ADDR_W+2];

  assign accept    = (state == S_IDLE) && i_valid;
  assign req_fault = lsu_fault(i_op, i_funct3, i_addr[1:0]);

  lsu_align u_align (
    .funct3   (f3_q),
    .addr_lo  (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_word  (i_dm_rdata),
    .st_ben   (st_ben),
    .st_wdata (st_wdata),
    .ld_data  (ld_data)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Request capture, fence settle counter and load result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q       <= OP_LOAD;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
      settle_cnt <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        op_q    <= lsu_op_e'(i_op);
        f3_q    <= i_funct3;
        addr_q  <= i_addr[ADDR_W+1:0];
        wdata_q <= i_wdata;
        fault_q <= req_fault;
      end
      // Loaded as fence.i is pulsed; main_mem only drops ready some cycles later,
      // so FSETTLE must not trust ready until the count has run out.
      if ((state == S_FENCE) && i_mem_ready)
        settle_cnt <= SETTLE_INIT;
      else if ((state == S_FSETTLE) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - CNT_W'(1);
      if (state == S_RDATA)
        rdata_q <= ld_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          if (req_fault)              state_nxt = S_RESP;
          else if (i_op == OP_FENCE)  state_nxt = S_FENCE;
          else                        state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_mem_ready) state_nxt = (op_q == OP_STORE) ? S_RESP : S_RDATA;
      end
      S_RDATA:   state_nxt = S_RESP;
      S_FENCE: begin
        if (i_mem_ready) state_nxt = S_FSETTLE;
      end
      S_FSETTLE: begin
        if ((settle_cnt == '0) && i_mem_ready) state_nxt = S_RESP;
      end
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_ready    = 1'b0;
    o_done     = 1'b0;
    o_fault    = 1'b0;
    o_dm_ren   = 1'b0;
    o_dm_wen   = 1'b0;
    o_dm_ben   = '0;
    o_dm_wdata = '0;
    o_fence_i  = 1'b0;
    case (state)
      S_IDLE: o_ready = 1'b1;
      S_ISSUE: begin
        if (i_mem_ready) begin
          if (op_q == OP_STORE) begin
            o_dm_wen   = 1'b1;
            o_dm_ben   = st_ben;
            o_dm_wdata = st_wdata;
          end else begin
            o_dm_ren = 1'b1;
            o_dm_ben = '1;
          end
        end
      end
      S_FENCE: o_fence_i = i_mem_ready;
      S_RESP: begin
        o_done  = 1'b1;
        o_fault = fault_q;
      end
      default: ;
    endcase
  end

  assign o_dm_addr = addr_q[ADDR_W+1:2];
  assign o_rdata   = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam int unsigned ADDR_W = 14;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_valid;
  logic              o_ready;
  logic [1:0]        i_op;
  logic [2:0]        i_funct3;
  logic [31:0]       i_addr;
  logic [31:0]       i_wdata;
  logic              o_done;
  logic              o_fault;
  logic [31:0]       o_rdata;
  logic              o_dm_ren;
  logic              o_dm_wen;
  logic [3:0]        o_dm_ben;
  logic [ADDR_W-1:0] o_dm_addr;
  logic [31:0]       o_dm_wdata;
  logic [31:0]       i_dm_rdata;
  logic              o_fence_i;
  logic              i_mem_ready;
  logic              mem_init;

  int n_vec = 0;
  int n_bad = 0;

  lsu_ctrl #(.ADDR_W(ADDR_W), .FENCE_SETTLE(2)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_done      (o_done),
    .o_fault     (o_fault),
    .o_rdata     (o_rdata),
    .o_dm_ren    (o_dm_ren),
    .o_dm_wen    (o_dm_wen),
    .o_dm_ben    (o_dm_ben),
    .o_dm_addr   (o_dm_addr),
    .o_dm_wdata  (o_dm_wdata),
    .i_dm_rdata  (i_dm_rdata),
    .o_fence_i   (o_fence_i),
    .i_mem_ready (i_mem_ready)
  );

  always #5 i_clk = ~i_clk;

  // Small main_mem stand-in: byte-enabled write, 1-cycle registered read.
  logic [31:0] mem [256];
  always @(posedge i_clk) begin
    if (mem_init) begin
      mem[8'h40] <= 32'h0000_0000;
      mem[8'h41] <= 32'h0000_0000;
      mem[8'h80] <= 32'h8001_1234;
      i_dm_rdata <= '0;
    end else begin
      if (o_dm_wen)
        for (int b = 0; b < 4; b++)
          if (o_dm_ben[b]) mem[o_dm_addr[7:0]][b*8 +: 8] <= o_dm_wdata[b*8 +: 8];
      if (o_dm_ren) i_dm_rdata <= mem[o_dm_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid;
    @(negedge i_clk);
  endtask

  task automatic accept(input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    chk("accept_ready", 32'(o_ready), 1);
    i_valid  = 1'b1;
    i_op     = op;
    i_funct3 = f3;
    i_addr   = a;
    i_wdata  = wd;
    step;
    i_valid  = 1'b0;
    i_op     = 2'b00;
    i_addr   = 32'hFFFF_FFFF;
    i_wdata  = 32'h0BAD_0BAD;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] eben,
                          input logic [31:0] ewd, input logic [31:0] eaddr);
    accept(OP_STORE, f3, a, wd);
    mid;
    chk({tag, "_wen"},   32'(o_dm_wen), 1);
    chk({tag, "_ren"},   32'(o_dm_ren), 0);
    chk({tag, "_ben"},   32'(o_dm_ben), 32'(eben));
    chk({tag, "_wdata"}, o_dm_wdata, ewd);
    chk({tag, "_addr"},  32'(o_dm_addr), eaddr);
    chk({tag, "_early"}, 32'(o_done), 0);
    step; mid;
    chk({tag, "_done"},  32'(o_done), 1);
    chk({tag, "_fault"}, 32'(o_fault), 0);
    chk({tag, "_wen2"},  32'(o_dm_wen), 0);
    step;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    accept(OP_LOAD, f3, a, 32'h0);
    mid;
    chk({tag, "_ren"},   32'(o_dm_ren), 1);
    chk({tag, "_wen"},   32'(o_dm_wen), 0);
    chk({tag, "_ben"},   32'(o_dm_ben), 32'hF);
    step; mid;
    chk({tag, "_early"}, 32'(o_done), 0);
    step; mid;
    chk({tag, "_done"},  32'(o_done), 1);
    chk({tag, "_fault"}, 32'(o_fault), 0);
    chk({tag, "_rdata"}, o_rdata, exp);
    step;
  endtask

  task automatic do_fault(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [31:0] a);
    accept(op, f3, a, 32'h5555_5555);
    mid;
    chk({tag, "_done"},   32'(o_done), 1);
    chk({tag, "_fault"},  32'(o_fault), 1);
    chk({tag, "_strobe"}, {29'h0, o_dm_ren, o_dm_wen, o_fence_i}, 0);
    step; mid;
    chk({tag, "_idle"},   32'(o_done), 0);
    step;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int fence_pulses;
    i_rst       = 1'b1;
    mem_init    = 1'b1;
    i_valid     = 1'b0;
    i_op        = 2'b00;
    i_funct3    = 3'b000;
    i_addr      = '0;
    i_wdata     = '0;
    i_mem_ready = 1'b1;
    step; step; mid;
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_done",  32'(o_done), 0);
    chk("rst_strb",  {28'h0, o_dm_ren, o_dm_wen, o_fence_i, o_fault}, 0);
    chk("rst_ben",   32'(o_dm_ben), 0);
    chk("rst_rdata", o_rdata, 0);
    step;
    i_rst    = 1'b0;
    mem_init = 1'b0;
    step;

    do_store("sw",  LS_W, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h40);
    do_store("sb",  LS_B, 32'h0000_0103, 32'h1234_56A5, 4'b1000, 32'hA5A5_A5A5, 32'h40);
    do_load ("lb",  LS_B,  32'h0000_0103, 32'hFFFF_FFA5);
    do_load ("lbu", LS_BU, 32'h0000_0103, 32'h0000_00A5);
    do_load ("lh",  LS_H,  32'h0000_0202, 32'hFFFF_8001);
    do_load ("lhu", LS_HU, 32'h0000_0202, 32'h0000_8001);

    do_fault("lw_mis",  OP_LOAD,    LS_W,   32'h0000_0202);
    do_fault("illegal", OP_ILLEGAL, LS_W,   32'h0000_0000);
    do_fault("st_f3",   OP_STORE,   3'b011, 32'h0000_0100);
    do_fault("lh_mis",  OP_LOAD,    LS_H,   32'h0000_0101);
    chk("rdata_hold", o_rdata, 32'h0000_8001);

    // Store stalled by main_mem ready low for five cycles.
    i_mem_ready = 1'b0;
    accept(OP_STORE, LS_W, 32'h0000_0104, 32'h1122_3344);
    for (int k = 1; k <= 5; k++) begin
      mid;
      chk("stall_strobe", {27'h0, o_dm_ben, o_dm_wen}, 0);
      chk("stall_ready",  32'(o_ready), 0);
      step;
    end
    i_mem_ready = 1'b1;
    mid;
    chk("stall_wen",   32'(o_dm_wen), 1);
    chk("stall_addr",  32'(o_dm_addr), 32'h41);
    chk("stall_wdata", o_dm_wdata, 32'h1122_3344);
    step; mid;
    chk("stall_done",  32'(o_done), 1);
    step; mid;
    chk("stall_once",  32'(o_done), 0);

    do_store("sh", LS_H, 32'h0000_0106, 32'h0000_CAFE, 4'b1100, 32'hCAFE_CAFE, 32'h41);
    chk("sh_rdata_hold", o_rdata, 32'h0000_8001);
    do_load ("lw_sh", LS_W, 32'h0000_0104, 32'hCAFE_3344);

    // fence.i: ready drops two cycles after the pulse and returns later.
    accept(OP_FENCE, 3'b000, 32'h0, 32'h0);
    fence_pulses = 0;
    mid;
    if (o_fence_i) fence_pulses++;
    chk("fence_pulse", 32'(o_fence_i), 1);
    for (int k = 2; k <= 6; k++) begin
      step;
      i_mem_ready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      mid;
      if (o_fence_i) fence_pulses++;
      chk("fence_wait", 32'(o_done), 0);
    end
    chk("fence_count", 32'(fence_pulses), 1);
    step; mid;
    chk("fence_done",  32'(o_done), 1);
    chk("fence_fault", 32'(o_fault), 0);
    step;

    // Reset while the load is waiting for read data.
    accept(OP_LOAD, LS_B, 32'h0000_0103, 32'h0);
    mid;
    chk("rst_mid_ren", 32'(o_dm_ren), 1);
    step;
    i_rst = 1'b1;
    mid;
    chk("rst_mid_rdata_state", 32'(o_done), 0);
    step;
    i_rst = 1'b0;
    mid;
    chk("rst_mid_ready", 32'(o_ready), 1);
    chk("rst_mid_done",  32'(o_done), 0);
    step; mid;
    chk("rst_mid_quiet", 32'(o_done), 0);
    step;
    do_load("lw_after", LS_W, 32'h0000_0100, 32'hA5AD_BEEF);
    do_load("lw_hi",    LS_W, 32'h8000_0100, 32'hA5AD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
